// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 arbiter: FSM state, transaction owner and the
// D-cache request qualifier.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_t;

    // Read and write together is not a request, matching the L2 no-flush rule.
    function automatic logic d_req_valid(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

endpackage

// File: rtl/l2_arbiter_rr_pick2.sv
// Two-way round-robin picker: bit 0 is the I-side, bit 1 the D-side.
// The priority pointer moves to the side opposite the granted one.
module rr_pick2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    logic prio_d_q;
    logic prio_d_d;

    // Grant selection; the pointer only matters on contention.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = prio_d_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    // After an I grant favour D, after a D grant favour I.
    always_comb begin
        prio_d_d = prio_d_q;
        if (update_i && (gnt_o != 2'b00)) begin
            prio_d_d = gnt_o[0];
        end else begin
            prio_d_d = prio_d_q;
        end
    end

    // Pointer register, reset favouring the I-side.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_d_q <= 1'b0;
        end else begin
            prio_d_q <= prio_d_d;
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Arbitrates the L1 I-cache and D-cache onto the single L2 port. One request
// is in flight at a time; all outputs come straight from registers.
module l2_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    import l2_arb_pkg::*;

    arb_state_t        state_q,    state_d;
    arb_owner_t        owner_q,    owner_d;
    logic              l2_read_q,  l2_read_d;
    logic              l2_write_q, l2_write_d;
    logic [ADDR_W-1:0] l2_addr_q,  l2_addr_d;
    logic [LINE_W-1:0] l2_wdata_q, l2_wdata_d;
    logic [LINE_W-1:0] i_rdata_q,  i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q,  d_rdata_d;
    logic              i_resp_q,   i_resp_d;
    logic              d_resp_q,   d_resp_d;

    logic [1:0]        req_s;
    logic [1:0]        gnt_s;
    logic              idle_s;

    assign req_s  = {d_req_valid(d_read, d_write), i_read};
    assign idle_s = (state_q == IDLE);

    rr_pick2 u_pick (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_s),
        .update_i (idle_s),
        .gnt_o    (gnt_s)
    );

    // FSM next state plus request/response latches.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        l2_read_d  = l2_read_q;
        l2_write_d = l2_write_q;
        l2_addr_d  = l2_addr_q;
        l2_wdata_d = l2_wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_resp_d   = 1'b0;
        d_resp_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_s[0]) begin
                    owner_d    = OWN_I;
                    l2_read_d  = 1'b1;
                    l2_write_d = 1'b0;
                    l2_addr_d  = i_addr;
                    state_d    = BUSY;
                end else if (gnt_s[1]) begin
                    owner_d    = OWN_D;
                    l2_read_d  = d_read;
                    l2_write_d = d_write;
                    l2_addr_d  = d_addr;
                    l2_wdata_d = d_wdata;
                    state_d    = BUSY;
                end else begin
                    state_d    = IDLE;
                end
            end
            BUSY: begin
                if (l2_resp) begin
                    l2_read_d  = 1'b0;
                    l2_write_d = 1'b0;
                    state_d    = RESP;
                    if (owner_q == OWN_I) begin
                        i_resp_d  = 1'b1;
                        i_rdata_d = l2_rdata;
                    end else if (owner_q == OWN_D) begin
                        d_resp_d = 1'b1;
                        // Write completions leave the read line untouched.
                        if (l2_read_q) begin
                            d_rdata_d = l2_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end else begin
                        i_resp_d = 1'b0;
                        d_resp_d = 1'b0;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            RESP: begin
                owner_d = OWN_NONE;
                state_d = IDLE;
            end
            default: begin
                owner_d    = OWN_NONE;
                l2_read_d  = 1'b0;
                l2_write_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_NONE;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            l2_addr_q  <= {ADDR_W{1'b0}};
            l2_wdata_q <= {LINE_W{1'b0}};
            i_rdata_q  <= {LINE_W{1'b0}};
            d_rdata_q  <= {LINE_W{1'b0}};
            i_resp_q   <= 1'b0;
            d_resp_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            l2_read_q  <= l2_read_d;
            l2_write_q <= l2_write_d;
            l2_addr_q  <= l2_addr_d;
            l2_wdata_q <= l2_wdata_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_resp_q   <= i_resp_d;
            d_resp_q   <= d_resp_d;
        end
    end

    assign i_rdata  = i_rdata_q;
    assign i_resp   = i_resp_q;
    assign d_rdata  = d_rdata_q;
    assign d_resp   = d_resp_q;
    assign l2_read  = l2_read_q;
    assign l2_write = l2_write_q;
    assign l2_addr  = l2_addr_q;
    assign l2_wdata = l2_wdata_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: expected transactions are queued in grant
// order, checked at the L2 port and again when the requester response arrives.
`timescale 1ns/1ps
module tb_l2_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] i_rdata, d_rdata, l2_wdata;
    logic          i_resp, d_resp, l2_read, l2_write;
    logic [AW-1:0] l2_addr;
    logic [LW-1:0] l2_rdata_m = '0, spur_data = '0;
    logic          l2_resp_m = 1'b0, spur = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int l2_lat   = 1;

    typedef struct {
        logic          own_d;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
    } exp_t;

    exp_t          sb_q[$];
    logic [LW-1:0] exp_i_rdata = '0, exp_d_rdata = '0;

    always #5 clk = ~clk;

    l2_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_read   (i_read),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_resp   (i_resp),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_resp   (d_resp),
        .l2_read  (l2_read),
        .l2_write (l2_write),
        .l2_addr  (l2_addr),
        .l2_wdata (l2_wdata),
        .l2_rdata (spur ? spur_data : l2_rdata_m),
        .l2_resp  (l2_resp_m | spur)
    );

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        if (a == 32'h0000_1000) return {32{8'hAA}};
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    task automatic push_exp(input logic own_d, input logic wr, input logic [AW-1:0] a,
                            input logic [LW-1:0] wd);
        exp_t e;
        e.own_d = own_d;
        e.wr    = wr;
        e.addr  = a;
        e.wdata = wd;
        if (wr) begin
            e.rdata = exp_d_rdata;
        end else begin
            e.rdata = line_of(a);
            if (own_d) exp_d_rdata = e.rdata;
            else       exp_i_rdata = e.rdata;
        end
        sb_q.push_back(e);
    endtask

    // L2 model: checks each new request against the scoreboard head, checks the
    // request stays stable, and pulses l2_resp after l2_lat cycles.
    bit            active = 1'b0;
    int            cnt = 0;
    logic [AW-1:0] cap_addr;
    logic          cap_wr;
    logic [LW-1:0] cap_wdata;
    always @(negedge clk) begin
        l2_resp_m = 1'b0;
        if (rst) begin
            active = 1'b0;
        end else if (l2_read || l2_write) begin
            if (!active) begin
                active = 1'b1;
                cnt = l2_lat;
                cap_addr = l2_addr;
                cap_wr = l2_write;
                cap_wdata = l2_wdata;
                if (sb_q.size() == 0) begin
                    check("l2_unexpected", 1, 0);
                end else begin
                    check("l2_addr", l2_addr, sb_q[0].addr);
                    check("l2_op", {l2_read, l2_write}, sb_q[0].wr ? 2'b01 : 2'b10);
                    if (sb_q[0].wr) check("l2_wdata", l2_wdata, sb_q[0].wdata);
                end
            end else begin
                check("l2_stable", {l2_write, l2_addr, l2_wdata} == {cap_wr, cap_addr, cap_wdata}, 1'b1);
            end
            cnt--;
            if (cnt <= 0) begin
                l2_resp_m = 1'b1;
                l2_rdata_m = line_of(cap_addr);
                active = 1'b0;
            end
        end
    end

    // Response monitor: pops the scoreboard on every requester response.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("onehot", $countones({l2_read, l2_write, i_resp, d_resp}) <= 1, 1'b1);
            if (i_resp || d_resp) begin
                if (sb_q.size() == 0) begin
                    check("resp_unexpected", {i_resp, d_resp}, 2'b00);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_owner", {i_resp, d_resp}, e.own_d ? 2'b01 : 2'b10);
                    if (e.own_d) check("d_rdata", d_rdata, e.rdata);
                    else         check("i_rdata", i_rdata, e.rdata);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        spur = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        exp_i_rdata = '0;
        exp_d_rdata = '0;
    endtask

    task automatic i_txn(input logic [AW-1:0] a, output int n);
        @(posedge clk); #1;
        i_read = 1'b1; i_addr = a;
        n = 0;
        do begin @(negedge clk); n++; end while (!i_resp && n < 100);
        if (!i_resp) check("i_timeout", 0, 1);
        @(posedge clk); #1;
        i_read = 1'b0;
    endtask

    task automatic d_txn(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [LW-1:0] wd, output int n);
        @(posedge clk); #1;
        d_read = rd; d_write = wr; d_addr = a; d_wdata = wd;
        n = 0;
        do begin @(negedge clk); n++; end while (!d_resp && n < 100);
        if (!d_resp) check("d_timeout", 0, 1);
        @(posedge clk); #1;
        d_read = 1'b0; d_write = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, ni, nd;
        do_reset();
        @(negedge clk);
        check("rst_l2_req", {l2_read, l2_write, i_resp, d_resp}, 4'b0000);
        check("rst_l2_addr", l2_addr, 0);
        check("rst_l2_wdata", l2_wdata, 0);
        check("rst_rdata", {i_rdata, d_rdata} == 512'd0, 1'b1);

        // Lone I read, one-cycle L2 hit.
        l2_lat = 1;
        push_exp(1'b0, 1'b0, 32'h0000_1000, '0);
        i_txn(32'h0000_1000, n);
        check("i_latency", n, 3);
        check("i_line", i_rdata, {32{8'hAA}});

        // D write with 5-cycle L2 latency.
        l2_lat = 5;
        push_exp(1'b1, 1'b1, 32'h0000_2040, {32{8'h55}});
        d_txn(1'b0, 1'b1, 32'h0000_2040, {32{8'h55}}, n);
        check("d_latency", n, 7);
        check("sb_drain_1", sb_q.size(), 0);

        // Contention from reset: I, D, I, D.
        do_reset();
        l2_lat = 2;
        push_exp(1'b0, 1'b0, 32'h0000_0100, '0);
        push_exp(1'b1, 1'b0, 32'h0000_0200, '0);
        push_exp(1'b0, 1'b0, 32'h0000_0300, '0);
        push_exp(1'b1, 1'b0, 32'h0000_0400, '0);
        fork
            begin
                i_txn(32'h0000_0100, ni);
                i_txn(32'h0000_0300, ni);
            end
            begin
                d_txn(1'b1, 1'b0, 32'h0000_0200, '0, nd);
                d_txn(1'b1, 1'b0, 32'h0000_0400, '0, nd);
            end
        join
        check("sb_drain_2", sb_q.size(), 0);

        // Lone I grant moves the pointer to D; next contention serves D first.
        push_exp(1'b0, 1'b0, 32'h0000_0500, '0);
        i_txn(32'h0000_0500, n);
        push_exp(1'b1, 1'b0, 32'h0000_0600, '0);
        push_exp(1'b0, 1'b0, 32'h0000_0700, '0);
        fork
            i_txn(32'h0000_0700, ni);
            d_txn(1'b1, 1'b0, 32'h0000_0600, '0, nd);
        join
        check("sb_drain_3", sb_q.size(), 0);

        // Read and write together is not a request.
        @(posedge clk); #1;
        d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_0800;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("illegal_d", {l2_read, l2_write, i_resp, d_resp}, 4'b0000);
        end
        @(posedge clk); #1;
        d_read = 1'b0; d_write = 1'b0;

        // Reset while BUSY abandons the transaction.
        l2_lat = 20;
        push_exp(1'b0, 1'b0, 32'h0000_3000, '0);
        @(posedge clk); #1;
        i_read = 1'b1; i_addr = 32'h0000_3000;
        n = 0;
        do begin @(negedge clk); n++; end while (!l2_read && n < 10);
        check("busy_seen", l2_read, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1; i_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        @(negedge clk);
        check("midrst_req", {l2_read, l2_write, i_resp, d_resp}, 4'b0000);
        check("midrst_addr", l2_addr, 0);
        check("midrst_rdata", {i_rdata, d_rdata} == 512'd0, 1'b1);
        l2_lat = 2;
        push_exp(1'b1, 1'b0, 32'h0000_4000, '0);
        d_txn(1'b1, 1'b0, 32'h0000_4000, '0, n);
        check("post_rst_latency", n, 4);

        // Spurious l2_resp in IDLE.
        @(posedge clk); #1;
        spur = 1'b1; spur_data = {LW{1'b1}};
        @(posedge clk); #1;
        spur = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("spur_resp", {i_resp, d_resp}, 2'b00);
        end
        check("spur_i_rdata", i_rdata, exp_i_rdata);
        check("spur_d_rdata", d_rdata, exp_d_rdata);
        check("sb_drain_end", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
